// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared opcodes, class codes and loader state enum
package instr_encoder_pkg;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_S    = 7'b0100011;
    localparam logic [6:0] OPC_B    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    localparam logic [2:0] CLS_R    = 3'd0;
    localparam logic [2:0] CLS_I    = 3'd1;
    localparam logic [2:0] CLS_S    = 3'd2;
    localparam logic [2:0] CLS_B    = 3'd3;
    localparam logic [2:0] CLS_LOAD = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Codes above LOAD have no encoding and are rejected by the loader.
    function automatic logic class_legal(input logic [2:0] cls);
        return cls <= CLS_LOAD;
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// rtl/instr_encoder_pack.sv - combinational field-to-RV32I word encoder
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] imm,
    output logic [31:0] word
);

    // Place fields per instruction class; unused fields and illegal classes give zero.
    always_comb begin
        word = '0;
        case (cls)
            CLS_R:    word = {1'b0, alt, 5'b00000, rs2, rs1, funct3, rd, OPC_R};
            CLS_I: begin
                // Shifts carry shamt in imm[4:0] and use instr[30] as the arithmetic select.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    word = {1'b0, alt, 5'b00000, imm[4:0], rs1, funct3, rd, OPC_I};
                end else begin
                    word = {imm, rs1, funct3, rd, OPC_I};
                end
            end
            CLS_LOAD: word = {imm, rs1, funct3, rd, OPC_LOAD};
            CLS_S:    word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_S};
            // imm holds byte offset[12:1], so imm[11] is offset bit 12 and imm[10] is bit 11.
            CLS_B:    word = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], OPC_B};
            default:  word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - program loader: encodes requests and writes them to instruction memory
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_class,
    input  logic [2:0]        req_funct3,
    input  logic              req_alt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [11:0]       req_imm,
    input  logic              req_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [31:0]       packed_word;

    instr_pack u_pack (
        .cls    (req_class),
        .funct3 (req_funct3),
        .alt    (req_alt),
        .rd     (req_rd),
        .rs1    (req_rs1),
        .rs2    (req_rs2),
        .imm    (req_imm),
        .word   (packed_word)
    );

    // Next-state logic for the accept / write / done sequence.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (class_legal(req_class)) begin
                        wdata_d = packed_word;
                        last_d  = req_last;
                        state_d = ST_WRITE;
                    end else begin
                        // Illegal request is consumed but never reaches memory.
                        err_d = 1'b1;
                        if (req_last) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    addr_d = addr_q + ADDR_ONE;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + COUNT_ONE;
                    end
                    state_d = last_q ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                if (restart) begin
                    addr_d  = BASE_ADDR;
                    count_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; a pending write is simply dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign mem_we    = (state_q == ST_WRITE);
    assign done      = (state_q == ST_DONE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        restart = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_class = '0;
    logic [2:0]  req_funct3 = '0;
    logic        req_alt = 1'b0;
    logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
    logic [11:0] req_imm = '0;
    logic        req_last = 1'b0;
    logic        mem_ack = 1'b0;

    logic        req_ready, mem_we, done, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  count;

    logic        req_ready_s, mem_we_s, done_s, err_s;
    logic [1:0]  mem_addr_s;
    logic [31:0] mem_wdata_s;
    logic [2:0]  count_s;

    int pass_cnt = 0;
    int total_cnt = 0;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_funct3(req_funct3), .req_alt(req_alt),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .req_last(req_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .count(count), .done(done), .err(err)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut_small (
        .clk(clk), .reset(reset), .restart(restart),
        .req_valid(req_valid), .req_ready(req_ready_s),
        .req_class(req_class), .req_funct3(req_funct3), .req_alt(req_alt),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_imm(req_imm), .req_last(req_last),
        .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
        .mem_ack(mem_ack), .count(count_s), .done(done_s), .err(err_s)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_req(input logic [2:0] c, input logic [2:0] f3, input logic alt,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [11:0] imm, input logic last);
        req_class = c; req_funct3 = f3; req_alt = alt;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_last = last;
    endtask

    // Presents one request, waits (bounded) for the write strobe, records it, then acks.
    task automatic do_write(input logic [2:0] c, input logic [2:0] f3, input logic alt,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [11:0] imm, input logic last,
                            output logic [31:0] w, output logic [7:0] a,
                            output logic [1:0] a_s, output logic seen);
        @(negedge clk);
        set_req(c, f3, alt, rd, rs1, rs2, imm, last);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_last = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (mem_we) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        w = mem_wdata;
        a = mem_addr;
        a_s = mem_addr_s;
        if (seen) begin
            @(negedge clk);
            mem_ack = 1'b1;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready); else pass_cnt++;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL reset_we got %b exp 0", mem_we); else pass_cnt++;
        total_cnt++; if (mem_addr !== 8'd0) $display("FAIL reset_addr got %h exp 00", mem_addr); else pass_cnt++;
        total_cnt++; if (mem_wdata !== 32'd0) $display("FAIL reset_wdata got %h exp 0", mem_wdata); else pass_cnt++;
        total_cnt++; if (count !== 9'd0) $display("FAIL reset_count got %0d exp 0", count); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_encode();
        logic [31:0] w; logic [7:0] a; logic [1:0] a_s; logic seen;
        logic [2:0]  vc  [7] = '{3'd0, 3'd0, 3'd2, 3'd4, 3'd3, 3'd1, 3'd1};
        logic [2:0]  vf3 [7] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd1, 3'd5};
        logic        valt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [4:0]  vrd [7] = '{5'd3, 5'd3, 5'd0, 5'd4, 5'd0, 5'd1, 5'd1};
        logic [4:0]  vrs1[7] = '{5'd1, 5'd1, 5'd2, 5'd1, 5'd1, 5'd1, 5'd1};
        logic [4:0]  vrs2[7] = '{5'd2, 5'd2, 5'd5, 5'd0, 5'd2, 5'd0, 5'd0};
        logic [11:0] vimm[7] = '{12'd0, 12'd0, 12'd8, 12'd4, 12'h004, 12'd3, 12'd3};
        logic [31:0] vexp[7] = '{32'h002081B3, 32'h402081B3, 32'h00512423, 32'h0040A203,
                                 32'h00208463, 32'h00309093, 32'h4030D093};
        for (int i = 0; i < 7; i++) begin
            do_write(vc[i], vf3[i], valt[i], vrd[i], vrs1[i], vrs2[i], vimm[i], 1'b0, w, a, a_s, seen);
            total_cnt++; if (seen !== 1'b1) $display("FAIL enc%0d_we got %b exp 1", i, seen); else pass_cnt++;
            total_cnt++; if (w !== vexp[i]) $display("FAIL enc%0d_word got %h exp %h", i, w, vexp[i]); else pass_cnt++;
            total_cnt++; if (a !== 8'(i)) $display("FAIL enc%0d_addr got %0d exp %0d", i, a, i); else pass_cnt++;
        end
        total_cnt++; if (count !== 9'd7) $display("FAIL enc_count got %0d exp 7", count); else pass_cnt++;
    endtask

    task automatic test_ack_delay();
        @(negedge clk);
        set_req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (mem_we !== 1'b1) $display("FAIL hold%0d_we got %b exp 1", i, mem_we); else pass_cnt++;
            total_cnt++; if (mem_addr !== 8'd7) $display("FAIL hold%0d_addr got %0d exp 7", i, mem_addr); else pass_cnt++;
            total_cnt++; if (mem_wdata !== 32'h002081B3) $display("FAIL hold%0d_wdata got %h exp 002081b3", i, mem_wdata); else pass_cnt++;
            total_cnt++; if (req_ready !== 1'b0) $display("FAIL hold%0d_ready got %b exp 0", i, req_ready); else pass_cnt++;
            total_cnt++; if (count !== 9'd7) $display("FAIL hold%0d_count got %0d exp 7", i, count); else pass_cnt++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL hold_we_drop got %b exp 0", mem_we); else pass_cnt++;
        total_cnt++; if (count !== 9'd8) $display("FAIL hold_count got %0d exp 8", count); else pass_cnt++;
        total_cnt++; if (mem_addr !== 8'd8) $display("FAIL hold_addr_inc got %0d exp 8", mem_addr); else pass_cnt++;
    endtask

    task automatic test_illegal();
        logic [31:0] w; logic [7:0] a; logic [1:0] a_s; logic seen;
        @(negedge clk);
        set_req(3'd6, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        total_cnt++; if (err !== 1'b1) $display("FAIL ill_err got %b exp 1", err); else pass_cnt++;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL ill_we got %b exp 0", mem_we); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL ill_ready got %b exp 1", req_ready); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL ill_we2 got %b exp 0", mem_we); else pass_cnt++;
        total_cnt++; if (count !== 9'd8) $display("FAIL ill_count got %0d exp 8", count); else pass_cnt++;
        do_write(3'd4, 3'd2, 1'b0, 5'd4, 5'd1, 5'd0, 12'd4, 1'b0, w, a, a_s, seen);
        total_cnt++; if (seen !== 1'b1) $display("FAIL ill_next_we got %b exp 1", seen); else pass_cnt++;
        total_cnt++; if (w !== 32'h0040A203) $display("FAIL ill_next_word got %h exp 0040a203", w); else pass_cnt++;
        total_cnt++; if (a !== 8'd8) $display("FAIL ill_next_addr got %0d exp 8", a); else pass_cnt++;
    endtask

    task automatic test_last_restart();
        logic [31:0] w; logic [7:0] a; logic [1:0] a_s; logic seen;
        apply_reset();
        @(negedge clk);
        set_req(3'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0, 1'b0);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        do_write(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0, w, a, a_s, seen);
        do_write(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0, w, a, a_s, seen);
        do_write(3'd2, 3'd2, 1'b0, 5'd0, 5'd2, 5'd5, 12'd8, 1'b1, w, a, a_s, seen);
        total_cnt++; if (a !== 8'd2) $display("FAIL last_addr got %0d exp 2", a); else pass_cnt++;
        total_cnt++; if (done !== 1'b1) $display("FAIL last_done got %b exp 1", done); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b0) $display("FAIL last_ready got %b exp 0", req_ready); else pass_cnt++;
        total_cnt++; if (count !== 9'd3) $display("FAIL last_count got %0d exp 3", count); else pass_cnt++;
        @(negedge clk);
        set_req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);
        req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL done_ign_we got %b exp 0", mem_we); else pass_cnt++;
        total_cnt++; if (count !== 9'd3) $display("FAIL done_ign_count got %0d exp 3", count); else pass_cnt++;
        total_cnt++; if (done !== 1'b1) $display("FAIL done_hold got %b exp 1", done); else pass_cnt++;
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        total_cnt++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else pass_cnt++;
        total_cnt++; if (mem_addr !== 8'd0) $display("FAIL rst_addr got %0d exp 0", mem_addr); else pass_cnt++;
        total_cnt++; if (count !== 9'd0) $display("FAIL rst_count got %0d exp 0", count); else pass_cnt++;
        total_cnt++; if (err !== 1'b1) $display("FAIL rst_err_hold got %b exp 1", err); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] w; logic [7:0] a; logic [1:0] a_s; logic seen;
        logic [1:0] exp_a [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            do_write(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 12'(i), 1'b0, w, a, a_s, seen);
            total_cnt++; if (a_s !== exp_a[i]) $display("FAIL wrap%0d_addr got %0d exp %0d", i, a_s, exp_a[i]); else pass_cnt++;
        end
        total_cnt++; if (count_s !== 3'd4) $display("FAIL wrap_count_sat got %0d exp 4", count_s); else pass_cnt++;
        total_cnt++; if (mem_addr_s !== 2'd1) $display("FAIL wrap_addr_next got %0d exp 1", mem_addr_s); else pass_cnt++;
        total_cnt++; if (count !== 9'd5) $display("FAIL wrap_count_wide got %0d exp 5", count); else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        set_req(3'd6, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 12'd0, 1'b0);
        req_valid = 1'b1;
        @(negedge clk);
        set_req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'd0, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        total_cnt++; if (mem_we !== 1'b1) $display("FAIL mid_pre_we got %b exp 1", mem_we); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL mid_we got %b exp 0", mem_we); else pass_cnt++;
        total_cnt++; if (mem_addr !== 8'd0) $display("FAIL mid_addr got %0d exp 0", mem_addr); else pass_cnt++;
        total_cnt++; if (mem_wdata !== 32'd0) $display("FAIL mid_wdata got %h exp 0", mem_wdata); else pass_cnt++;
        total_cnt++; if (count !== 9'd0) $display("FAIL mid_count got %0d exp 0", count); else pass_cnt++;
        total_cnt++; if (err !== 1'b0) $display("FAIL mid_err got %b exp 0", err); else pass_cnt++;
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL mid_ready got %b exp 1", req_ready); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL mid_done got %b exp 0", done); else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_encode();
        test_ack_delay();
        test_illegal();
        test_last_restart();
        test_wrap();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the control-unit decode path. Accepts one field-level instruction request per handshake and encodes it into a 32-bit RV32I word.
- Covers the five classes the control unit decodes: R, I, S, B and load.
- Writes each word into instruction memory at an auto-incrementing address, with an ack handshake. Acts as the program loader feeding the fetch/decode path.
- Flags illegal requests, and signals completion after the request marked last.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- BASE_ADDR, 0, first write address after reset or restart (ADDR_W bits).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- restart  in  1  leave DONE; return to IDLE with address back at BASE_ADDR
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_class  in  3  0=R, 1=I, 2=S, 3=B, 4=LOAD, 5-7 illegal
- req_funct3  in  3  funct3 field
- req_alt  in  1  instr[30] (sub/sra/srai select)
- req_rd, req_rs1, req_rs2  in  5 each  register indices
- req_imm  in  12  I/S/LOAD: imm[11:0]; B: byte offset[12:1]
- req_last  in  1  final instruction of the program
- mem_we  out  1  write strobe, held until ack
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction
- mem_ack  in  1  memory accepted the write
- count  out  ADDR_W+1  words written since reset/restart
- done  out  1  high in DONE
- err  out  1  sticky illegal-class flag

Behaviour:
- Reset (reset==0 at clk edge) values:
  - state=IDLE, req_ready=1, mem_we=0, mem_addr=BASE_ADDR.
  - mem_wdata=0, count=0, done=0, err=0.
  - Reset mid-write drops the pending word; no ack is needed.
- Opcodes: R 0110011, I 0010011, S 0100011, B 1100011, LOAD 0000011.
- Field placement common to all classes: rs1 at [19:15], funct3 at [14:12].
- R encoding:
  - [31:25]={0,alt,00000}, [24:20]=rs2, [11:7]=rd.
- I encoding:
  - funct3 001/101 (shifts): [31:25]={0,alt,00000}, [24:20]=imm[4:0].
  - Other funct3: [31:20]=imm[11:0].
  - [11:7]=rd.
- LOAD encoding: [31:20]=imm, [11:7]=rd. funct3 passes through unchanged.
- S encoding:
  - [31:25]=imm[11:5], [24:20]=rs2, [11:7]=imm[4:0].
- B encoding (i = req_imm):
  - [31]=i[11], [30:25]=i[9:4], [24:20]=rs2.
  - [11:8]=i[3:0], [7]=i[10].
- Unused fields are zero-filled.
- FSM states: IDLE, WRITE, DONE.
  - IDLE, req_valid=1, legal class: capture the encoded word into mem_wdata and the last flag; go to WRITE. mem_we=1 from the next cycle (1-cycle latency).
  - IDLE, req_valid=1, illegal class: consume the request, set err, stay in IDLE, write nothing. If req_last was set, go to DONE instead.
  - WRITE: mem_we=1; mem_addr and mem_wdata are stable until mem_ack.
  - WRITE, mem_ack=1: mem_we drops next cycle, mem_addr+1, count+1. Go to DONE if captured last, else IDLE.
  - Max throughput is 1 word per 2 cycles (ack in the first WRITE cycle).
  - DONE: done=1, req_ready=0, requests ignored.
  - DONE, restart=1: go to IDLE, mem_addr=BASE_ADDR, count=0. err holds.
  - restart is ignored outside DONE.
- mem_addr wraps from 2^ADDR_W-1 to 0 with no error. count saturates at 2^ADDR_W.
- err clears only on reset.

Decomposition:
- Shared package holds:
  - the opcode constants (also used by the control unit);
  - the class encodings;
  - the state enum.
- Natural sub-module: instr_pack. A purely combinational field-to-word encoder that reuses the package opcodes. The FSM, address counter and handshake live in the top module.

Test Plan:
- R add x3,x1,x2 (class 0, f3 0, alt 0) -> mem_wdata 0x002081B3 at addr 0. With alt=1 -> 0x402081B3 at addr 1.
- S sw x5,8(x2) (class 2, f3 010, imm 8) -> 0x00512423. LOAD lw x4,4(x1) -> 0x0040A203.
- B beq x1,x2,+8 (class 3, req_imm 0x004) -> 0x00208463. I slli x1,x1,3 -> 0x00309093. srai alt=1 -> 0x40... form with bit30 set.
- Delay mem_ack 3 cycles -> mem_we, mem_addr and mem_wdata hold; req_ready=0 throughout; count increments once.
- Class 6 request -> err=1, no mem_we, count unchanged. A subsequent legal request is still written.
- Ordering, wrap and restart:
  - req_last on the 3rd word -> done=1, req_ready=0, further requests ignored; restart -> addr=BASE_ADDR, count=0.
  - ADDR_W=2 with 5 writes -> addresses 0,1,2,3,0.
  - reset=0 during WRITE -> all outputs return to reset values next edge.
